// File: rtl/seq_001_tx_if.sv
// Word-in / serial-out port bundle for the "001"-sync serial transmitter.
// A word transfers on a rising clk edge where din_valid and din_ready are both 1.
// din_ready comes from a register, so it never depends on din_valid.
// din_valid may drop or din may change while din_ready is 0 without effect.
interface seq_001_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              xout;
  logic              busy;
  logic              done;

  modport master (
    output din, din_valid,
    input  din_ready, xout, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, xout, busy, done
  );
endinterface

// File: rtl/seq_001_tx.sv
// Serial framer: each accepted word is sent as "001", the payload MSB first, then GAP_BITS idle-high bits.
// All outputs are registered from the next-state values, so they line up with the state they describe.
module seq_001_tx #(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 1
) (
  input  logic         clk,
  input  logic         reset,
  seq_001_tx_if.slave  bus,
  output logic [1:0]   state_dbg
);
  localparam int BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_W - 1);
  localparam logic [3:0]        GAP_LAST  = 4'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [1:0]        sidx, sidx_n;
  logic [BIDX_W-1:0] bidx, bidx_n;
  logic [3:0]        gcnt, gcnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic              fire;
  logic              xout_n, busy_n, done_n, ready_n;

  assign fire      = bus.din_valid && bus.din_ready;
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    sidx_n  = sidx;
    bidx_n  = bidx;
    gcnt_n  = gcnt;
    sh_n    = sh;
    case (state)
      IDLE: begin
        if (fire) begin
          state_n = SYNC;
          sidx_n  = 2'd0;
          sh_n    = bus.din;
        end
      end
      SYNC: begin
        if (sidx == 2'd2) begin
          state_n = DATA;
          bidx_n  = '0;
        end else begin
          sidx_n = sidx + 2'd1;
        end
      end
      DATA: begin
        if (bidx == BIDX_LAST) begin
          state_n = GAP;
          gcnt_n  = 4'd0;
        end else begin
          bidx_n = bidx + BIDX_W'(1);
          sh_n   = sh << 1;
        end
      end
      GAP: begin
        // A word accepted on the last gap bit chains straight into the next SYNC.
        if (gcnt == GAP_LAST) begin
          if (fire) begin
            state_n = SYNC;
            sidx_n  = 2'd0;
            sh_n    = bus.din;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gcnt_n = gcnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n != IDLE);
    done_n  = (state_n == GAP) && (gcnt_n == GAP_LAST);
    ready_n = (state_n == IDLE) || done_n;
    case (state_n)
      SYNC:    xout_n = (sidx_n == 2'd2);
      DATA:    xout_n = sh_n[DATA_W-1];
      default: xout_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sidx          <= 2'd0;
      bidx          <= '0;
      gcnt          <= 4'd0;
      sh            <= '0;
      bus.xout      <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.din_ready <= 1'b1;
    end else begin
      state         <= state_n;
      sidx          <= sidx_n;
      bidx          <= bidx_n;
      gcnt          <= gcnt_n;
      sh            <= sh_n;
      bus.xout      <= xout_n;
      bus.busy      <= busy_n;
      bus.done      <= done_n;
      bus.din_ready <= ready_n;
    end
  end
endmodule

// File: tb/tb_seq_001_tx.sv
// Directed bench for seq_001_tx: default instance (8/1) and a 4-bit / 3-gap instance.
// Expected {xout,busy,done,din_ready} per cycle is queued on each modelled transfer.
module tb_seq_001_tx;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] st0, st1;

  always #5 clk = ~clk;

  seq_001_tx_if #(.DATA_W(8)) bus0 ();
  seq_001_tx_if #(.DATA_W(4)) bus1 ();

  seq_001_tx #(.DATA_W(8), .GAP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .state_dbg(st0)
  );
  seq_001_tx #(.DATA_W(4), .GAP_BITS(3)) u1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .state_dbg(st1)
  );

  // entry = {xout, busy, done, din_ready}
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic       rdy0, rdy1;
  logic [2:0] hist0;
  int         det0;
  int         vectors;
  int         miscompares;
  int         cyc;

  task automatic push0(input logic [7:0] d);
    for (int i = 0; i < 3; i++) exp_q0.push_back({(i == 2), 1'b1, 1'b0, 1'b0});
    for (int i = 7; i >= 0; i--) exp_q0.push_back({d[i], 1'b1, 1'b0, 1'b0});
    exp_q0.push_back(4'b1111);
  endtask

  task automatic push1(input logic [3:0] d);
    for (int i = 0; i < 3; i++) exp_q1.push_back({(i == 2), 1'b1, 1'b0, 1'b0});
    for (int i = 3; i >= 0; i--) exp_q1.push_back({d[i], 1'b1, 1'b0, 1'b0});
    for (int g = 0; g < 3; g++) exp_q1.push_back({1'b1, 1'b1, (g == 2), (g == 2)});
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc %0d obs=%b exp=%b", tag, cyc, obs, exp);
    end
  endtask

  // One clock: model the handshake, advance, then compare at the falling edge.
  task automatic cycle();
    logic [3:0] e0, e1;
    if (bus0.din_valid && rdy0) push0(bus0.din);
    if (bus1.din_valid && rdy1) push1(bus1.din);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e0 = (exp_q0.size() != 0) ? exp_q0.pop_front() : 4'b1001;
    e1 = (exp_q1.size() != 0) ? exp_q1.pop_front() : 4'b1001;
    check("u0", {bus0.xout, bus0.busy, bus0.done, bus0.din_ready}, e0);
    check("u1", {bus1.xout, bus1.busy, bus1.done, bus1.din_ready}, e1);
    rdy0 = e0[0];
    rdy1 = e1[0];
    hist0 = {hist0[1:0], bus0.xout};
    if (hist0 == 3'b001) det0++;
  endtask

  task automatic flush_model();
    exp_q0.delete();
    exp_q1.delete();
    rdy0 = 1'b1;
    rdy1 = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; det0 = 0; hist0 = 3'b111;
    rdy0 = 1'b1; rdy1 = 1'b1;
    reset = 1'b1;
    bus0.din = '0; bus0.din_valid = 1'b0;
    bus1.din = '0; bus1.din_valid = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    cycle();

    // Single 0xA5 frame on u0 alongside 4'b1001 on u1, then idle.
    bus0.din = 8'hA5; bus0.din_valid = 1'b1;
    bus1.din = 4'b1001; bus1.din_valid = 1'b1;
    cycle();
    bus0.din_valid = 1'b0; bus1.din_valid = 1'b0;
    repeat (14) cycle();

    // Back-to-back 0x00 then 0xFF with din_valid held.
    bus0.din = 8'h00; bus0.din_valid = 1'b1;
    cycle();
    bus0.din = 8'hFF;
    repeat (12) cycle();
    bus0.din_valid = 1'b0;
    repeat (13) cycle();

    // 0x3C with random din/din_valid churn while the frame is busy.
    bus0.din = 8'h3C; bus0.din_valid = 1'b1;
    cycle();
    repeat (10) begin
      bus0.din = 8'($urandom_range(0, 255));
      bus0.din_valid = 1'($urandom_range(0, 1));
      cycle();
    end
    bus0.din_valid = 1'b0;
    repeat (4) cycle();

    // Reset during DATA: line must go high and busy low immediately.
    bus0.din = 8'h96; bus0.din_valid = 1'b1;
    bus1.din = 4'b0110; bus1.din_valid = 1'b1;
    cycle();
    bus0.din_valid = 1'b0; bus1.din_valid = 1'b0;
    repeat (8) cycle();
    reset = 1'b1;
    #1;
    check("async_rst", {bus0.xout, bus0.busy, bus0.done, bus0.din_ready}, 4'b1001);
    flush_model();
    @(negedge clk);
    cycle();
    reset = 1'b0;
    repeat (4) cycle();

    // Word offered on the very first edge after reset release.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    bus0.din = 8'h5A; bus0.din_valid = 1'b1;
    cycle();
    bus0.din_valid = 1'b0;
    repeat (13) cycle();

    // "001" detector on the line: exactly one hit per 0xFF frame.
    hist0 = 3'b111; det0 = 0;
    bus0.din = 8'hFF; bus0.din_valid = 1'b1;
    repeat (36) cycle();
    bus0.din_valid = 1'b0;
    repeat (13) cycle();
    vectors++;
    assert (det0 === 3) else begin
      miscompares++;
      $error("FAIL detector hits obs=%0d exp=3", det0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
